// File: rtl/mat_row_fetch.sv
// mat_row_fetch: Avalon-MM reader that fetches 64-bit matrix rows into a two-slot ping-pong buffer and streams them out as bytes
module mat_row_fetch #(
   parameter int          NUM_ROWS  = 8,
   parameter logic [31:0] BASE_ADDR = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [31:0] avm_address,
   output logic        avm_read,
   input  logic [63:0] avm_readdata,
   input  logic        avm_readdatavalid,
   input  logic        avm_waitrequest,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [2:0]  out_row,
   output logic [2:0]  out_col,
   output logic        out_last
);
   localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT_DATA = 2'd2, FILLED = 2'd3;
   localparam logic [3:0] NR   = 4'(NUM_ROWS);
   localparam logic [3:0] LAST = 4'(NUM_ROWS - 1);
   logic [1:0]  state, occ, occ_n;
   logic        pending, head, got, acc, pop, fin;
   logic [3:0]  req_row, drain_row;
   logic [2:0]  col;
   logic [63:0] slot0, slot1, cur;
   assign avm_read    = state == REQ;
   assign avm_address = BASE_ADDR + {28'd0, req_row};
   assign cur         = head ? slot1 : slot0;
   assign out_valid   = occ != 2'd0;
   assign out_data    = cur[{~col, 3'b000} +: 8];
   assign out_row     = drain_row[2:0];
   assign out_col     = col;
   assign out_last    = out_valid & (drain_row == LAST) & (col == 3'd7);
   assign acc         = out_valid & out_ready;
   assign pop         = acc & (col == 3'd7);
   assign fin         = acc & out_last;
   // only the read we actually issued may fill a slot; stray beats are dropped
   assign got         = (state == WAIT_DATA) & pending & avm_readdatavalid;
   assign occ_n       = occ + {1'b0, got} - {1'b0, pop};
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         pending   <= 1'b0;
         head      <= 1'b0;
         occ       <= 2'd0;
         req_row   <= 4'd0;
         drain_row <= 4'd0;
         col       <= 3'd0;
         slot0     <= 64'd0;
         slot1     <= 64'd0;
      end else begin
         done <= fin;
         occ  <= occ_n;
         if (got) begin
            if (head ^ occ[0]) slot1 <= avm_readdata;
            else slot0 <= avm_readdata;
            pending <= 1'b0;
         end
         if (acc) col <= col + 3'd1;
         if (pop) begin
            head      <= ~head;
            drain_row <= drain_row + 4'd1;
         end
         case (state)
            IDLE: if (start) begin
               state     <= REQ;
               busy      <= 1'b1;
               req_row   <= 4'd0;
               drain_row <= 4'd0;
               col       <= 3'd0;
               head      <= 1'b0;
               occ       <= 2'd0;
            end
            REQ: if (!avm_waitrequest) begin
               state   <= WAIT_DATA;
               pending <= 1'b1;
               req_row <= req_row + 4'd1;
            end
            WAIT_DATA: if (!pending | avm_readdatavalid)
               state <= (req_row == NR) ? FILLED : (occ_n[1] ? WAIT_DATA : REQ);
            default: ;
         endcase
         if (fin) begin
            state     <= IDLE;
            busy      <= 1'b0;
            drain_row <= 4'd0;
            col       <= 3'd0;
         end
      end
   end
endmodule

// File: tb/tb_mat_row_fetch.sv
// tb_mat_row_fetch: directed bench for mat_row_fetch with a fixed-latency ROM slave model
module tb_mat_row_fetch;
   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;
   logic start0, busy0, done0, rd0, rdv0, wr0, ov0, or0, ol0;
   logic [31:0] ad0;
   logic [63:0] rdd0;
   logic [7:0] od0;
   logic [2:0] orow0, ocol0;
   logic start1, busy1, done1, rd1, rdv1, wr1, ov1, ol1;
   logic [31:0] ad1;
   logic [63:0] rdd1;
   logic [7:0] od1;
   logic [2:0] orow1, ocol1;
   logic or1 = 1'b1;
   mat_row_fetch #(.NUM_ROWS(8), .BASE_ADDR(32'd0)) u0 (
      .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
      .avm_address(ad0), .avm_read(rd0), .avm_readdata(rdd0), .avm_readdatavalid(rdv0),
      .avm_waitrequest(wr0), .out_data(od0), .out_valid(ov0), .out_ready(or0),
      .out_row(orow0), .out_col(ocol0), .out_last(ol0));
   mat_row_fetch #(.NUM_ROWS(1), .BASE_ADDR(32'd5)) u1 (
      .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
      .avm_address(ad1), .avm_read(rd1), .avm_readdata(rdd1), .avm_readdatavalid(rdv1),
      .avm_waitrequest(wr1), .out_data(od1), .out_valid(ov1), .out_ready(or1),
      .out_row(orow1), .out_col(ocol1), .out_last(ol1));
   int errors = 0, checks = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   // ROM slave: byte c of the row at address a is {a[3:0], c}; data returns 14 cycles after acceptance
   function automatic logic [63:0] row_pat(input logic [3:0] a);
      logic [63:0] p;
      for (int c = 0; c < 8; c++) p[8*(7-c) +: 8] = {a, 4'(c)};
      return p;
   endfunction
   logic [31:0] stall_addr;
   int stall_len, stall_used = 0;
   logic [13:0] sv0 = '0, sv1 = '0;
   logic [63:0] sd0 [14], sd1 [14];
   assign wr0  = rd0 && ad0 == stall_addr && stall_used < stall_len;
   assign wr1  = 1'b0;
   assign rdv0 = sv0[13];
   assign rdd0 = sd0[13];
   assign rdv1 = sv1[13];
   assign rdd1 = sd1[13];
   always @(posedge clk) begin
      sv0 <= {sv0[12:0], rd0 & ~wr0};
      sv1 <= {sv1[12:0], rd1 & ~wr1};
      sd0[0] <= row_pat(ad0[3:0]);
      sd1[0] <= row_pat(ad1[3:0]);
      for (int k = 1; k < 14; k++) begin
         sd0[k] <= sd0[k-1];
         sd1[k] <= sd1[k-1];
      end
      if (rd0 & wr0) stall_used <= stall_used + 1;
   end
   // observer: records accepted bytes/reads and protocol violations
   logic [14:0] q0[$], q1[$];
   logic [31:0] acc0[$], acc1[$];
   int done0_cnt = 0, done1_cnt = 0, cyc_done0 = 0, cyc_last0 = 0, busy_bad = 0;
   int stall_cyc = 0, stall_bad = 0, drop_viol = 0, two_viol = 0, outst = 0, bufc = 0, max_outst = 0;
   logic prev_wait = 1'b0, prev_acc = 1'b0;
   logic [31:0] prev_ad = '0;
   always @(negedge clk) begin
      #2;
      if (ov0 & or0) q0.push_back({ol0, orow0, ocol0, od0});
      if (ov1 & or1) q1.push_back({ol1, orow1, ocol1, od1});
      if (rd0 & ~wr0) acc0.push_back(ad0);
      if (rd1 & ~wr1) acc1.push_back(ad1);
      if (done0) begin done0_cnt++; cyc_done0 = cyc; if (busy0) busy_bad++; end
      if (done1) done1_cnt++;
      if (ov0 & or0 & ol0) cyc_last0 = cyc;
      if (prev_wait && (!rd0 || ad0 !== prev_ad)) stall_bad++;
      if (rd0 & wr0) stall_cyc++;
      if (rd0 & prev_acc) drop_viol++;
      if (rd0 && bufc >= 2) two_viol++;
      prev_wait = rd0 & wr0;
      prev_ad = ad0;
      prev_acc = rd0 & ~wr0;
      if (reset) begin
         outst = 0;
         bufc = 0;
      end else begin
         if (rdv0 && outst > 0) begin outst--; bufc++; end
         if (rd0 & ~wr0) outst++;
         if (ov0 & or0 & ocol0 == 3'd7) bufc--;
         if (outst > max_outst) max_outst = outst;
      end
   end
   function automatic int stream_errs(input logic [14:0] q[$], input int base, input int nbytes, input logic [3:0] a0);
      int e = 0;
      logic [14:0] w;
      if (q.size() - base != nbytes) e++;
      for (int i = 0; i < nbytes && base + i < q.size(); i++) begin
         w = {i == nbytes - 1, 3'(i / 8), 3'(i % 8), a0 + 4'(i / 8), 4'(i % 8)};
         if (q[base+i] !== w) e++;
      end
      return e;
   endfunction
   task automatic wait_done0(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 4000 && !ok; k++) begin
         @(negedge clk);
         ok = done0;
      end
   endtask
   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h want=0", busy0); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got=%0h want=0", done0); end
      checks++; if (rd0 !== 1'b0) begin errors++; $display("FAIL reset_read got=%0h want=0", rd0); end
      checks++; if (ad0 !== 32'd0) begin errors++; $display("FAIL reset_addr got=%0h want=0", ad0); end
      checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h want=0", ov0); end
      checks++; if (od0 !== 8'd0) begin errors++; $display("FAIL reset_data got=%0h want=0", od0); end
      checks++; if (orow0 !== 3'd0) begin errors++; $display("FAIL reset_row got=%0h want=0", orow0); end
      checks++; if (ocol0 !== 3'd0) begin errors++; $display("FAIL reset_col got=%0h want=0", ocol0); end
      checks++; if (ol0 !== 1'b0) begin errors++; $display("FAIL reset_last got=%0h want=0", ol0); end
      checks++; if (ad1 !== 32'd5) begin errors++; $display("FAIL reset_addr_b5 got=%0h want=5", ad1); end
      reset = 1'b0;
      @(negedge clk);
   endtask
   task automatic test_basic;
      int b, a, d, t_rdv, t_ov, t_acc2, bad;
      bit ok;
      b = q0.size(); a = acc0.size(); d = done0_cnt;
      t_rdv = -1; t_ov = -1; t_acc2 = -1; ok = 1'b0; bad = 0;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL start_busy got=%0h want=1", busy0); end
      checks++; if (rd0 !== 1'b1) begin errors++; $display("FAIL start_read got=%0h want=1", rd0); end
      checks++; if (ad0 !== 32'd0) begin errors++; $display("FAIL start_addr got=%0h want=0", ad0); end
      for (int k = 0; k < 4000 && !ok; k++) begin
         @(negedge clk);
         if (rdv0 && t_rdv < 0) t_rdv = cyc;
         if (ov0 && t_ov < 0) t_ov = cyc;
         if (rd0 && !wr0 && t_rdv >= 0 && t_acc2 < 0 && cyc > t_rdv) t_acc2 = cyc;
         ok = done0;
      end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%0h want=0", busy0); end
      #3;
      checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got=no_done want=done"); end
      checks++; if (t_ov !== t_rdv + 1) begin errors++; $display("FAIL basic_valid_latency got=%0d want=%0d", t_ov, t_rdv + 1); end
      checks++; if (t_acc2 !== t_rdv + 1) begin errors++; $display("FAIL basic_prefetch got=%0d want=%0d", t_acc2, t_rdv + 1); end
      checks++; if (stream_errs(q0, b, 64, 4'd0) !== 0) begin errors++; $display("FAIL basic_stream got=%0d_bytes want=64_in_order", q0.size() - b); end
      checks++; if (acc0.size() - a !== 8) begin errors++; $display("FAIL basic_reads got=%0d want=8", acc0.size() - a); end
      for (int i = 0; i < 8 && a + i < acc0.size(); i++) if (acc0[a+i] !== 32'(i)) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL basic_read_addrs got=%0d_bad want=0", bad); end
      checks++; if (done0_cnt - d !== 1) begin errors++; $display("FAIL basic_done_count got=%0d want=1", done0_cnt - d); end
      checks++; if (cyc_done0 !== cyc_last0 + 1) begin errors++; $display("FAIL basic_done_timing got=%0d want=%0d", cyc_done0, cyc_last0 + 1); end
      checks++; if (busy_bad !== 0) begin errors++; $display("FAIL basic_busy_with_done got=%0d want=0", busy_bad); end
   endtask
   task automatic test_waitrequest;
      int b, a, s, bad;
      bit ok;
      b = q0.size(); a = acc0.size(); s = stall_cyc; bad = 0;
      stall_addr = 32'd2;
      stall_len = stall_used + 3;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      wait_done0(ok);
      #3;
      stall_addr = '1;
      checks++; if (!ok) begin errors++; $display("FAIL wait_timeout got=no_done want=done"); end
      checks++; if (stall_cyc - s !== 3) begin errors++; $display("FAIL wait_stall_cycles got=%0d want=3", stall_cyc - s); end
      checks++; if (stall_bad !== 0) begin errors++; $display("FAIL wait_addr_stable got=%0d want=0", stall_bad); end
      for (int i = 0; i < 8 && a + i < acc0.size(); i++) if (acc0[a+i] !== 32'(i)) bad++;
      checks++; if (acc0.size() - a !== 8 || bad !== 0) begin errors++; $display("FAIL wait_reads got=%0d_reads_%0d_bad want=8_0", acc0.size() - a, bad); end
      checks++; if (stream_errs(q0, b, 64, 4'd0) !== 0) begin errors++; $display("FAIL wait_stream got=%0d_bytes want=64_in_order", q0.size() - b); end
      checks++; if (drop_viol !== 0) begin errors++; $display("FAIL wait_read_drop got=%0d want=0", drop_viol); end
   endtask
   task automatic test_backpressure;
      int b, hold;
      bit ok, did;
      b = q0.size(); hold = 0; ok = 1'b0; did = 1'b0;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      for (int k = 0; k < 4000 && !ok; k++) begin
         @(negedge clk);
         ok = done0;
         if (hold > 0) begin
            or0 = 1'b0;
            hold--;
         end else if (ov0 && orow0 == 3'd3 && ocol0 == 3'd4 && !did) begin
            did = 1'b1;
            or0 = 1'b0;
            hold = 9;
         end else or0 = ~or0;
      end
      or0 = 1'b1;
      #3;
      checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got=no_done want=done"); end
      checks++; if (stream_errs(q0, b, 64, 4'd0) !== 0) begin errors++; $display("FAIL bp_stream got=%0d_bytes want=64_in_order", q0.size() - b); end
      checks++; if (max_outst > 1) begin errors++; $display("FAIL bp_outstanding got=%0d want<=1", max_outst); end
      checks++; if (two_viol !== 0) begin errors++; $display("FAIL bp_read_when_full got=%0d want=0", two_viol); end
   endtask
   task automatic test_start_busy;
      int b, a, d;
      bit ok;
      b = q0.size(); a = acc0.size(); d = done0_cnt; ok = 1'b0;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      for (int k = 0; k < 4000 && !ok; k++) begin
         @(negedge clk);
         ok = done0;
         start0 = (k == 5 || k == 40 || k == 90) ? busy0 : 1'b0;
      end
      start0 = 1'b0;
      repeat (30) @(negedge clk);
      #3;
      checks++; if (!ok) begin errors++; $display("FAIL sb_timeout got=no_done want=done"); end
      checks++; if (done0_cnt - d !== 1) begin errors++; $display("FAIL sb_done_count got=%0d want=1", done0_cnt - d); end
      checks++; if (stream_errs(q0, b, 64, 4'd0) !== 0) begin errors++; $display("FAIL sb_stream got=%0d_bytes want=64_in_order", q0.size() - b); end
      checks++; if (acc0.size() - a !== 8) begin errors++; $display("FAIL sb_reads got=%0d want=8", acc0.size() - a); end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL sb_idle_busy got=%0h want=0", busy0); end
   endtask
   task automatic test_reset_mid;
      int b, a, bad;
      bit ok, hit;
      hit = 1'b0; bad = 0;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      for (int k = 0; k < 4000 && !hit; k++) begin
         @(negedge clk);
         hit = rd0 && !wr0 && ad0 == 32'd4;
      end
      checks++; if (!hit) begin errors++; $display("FAIL rm_row4_timeout got=no_read want=read_4"); end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rm_busy got=%0h want=0", busy0); end
      checks++; if (rd0 !== 1'b0 || ad0 !== 32'd0) begin errors++; $display("FAIL rm_bus got=%0h/%0h want=0/0", rd0, ad0); end
      checks++; if (ov0 !== 1'b0 || od0 !== 8'd0 || ol0 !== 1'b0) begin errors++; $display("FAIL rm_out got=%0h/%0h/%0h want=0/0/0", ov0, od0, ol0); end
      checks++; if (orow0 !== 3'd0 || ocol0 !== 3'd0) begin errors++; $display("FAIL rm_idx got=%0h/%0h want=0/0", orow0, ocol0); end
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (ov0 || busy0 || rd0 || done0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL rm_stray got=%0d_active_cycles want=0", bad); end
      #3;
      b = q0.size(); a = acc0.size();
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      wait_done0(ok);
      #3;
      checks++; if (!ok) begin errors++; $display("FAIL rm_timeout got=no_done want=done"); end
      checks++; if (acc0.size() - a < 1 || acc0[a] !== 32'd0) begin errors++; $display("FAIL rm_restart_addr got=%0d_reads want=first_at_0", acc0.size() - a); end
      checks++; if (stream_errs(q0, b, 64, 4'd0) !== 0) begin errors++; $display("FAIL rm_stream got=%0d_bytes want=64_in_order", q0.size() - b); end
   endtask
   task automatic test_single_row;
      int b, a, d;
      bit ok;
      b = q1.size(); a = acc1.size(); d = done1_cnt; ok = 1'b0;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int k = 0; k < 1000 && !ok; k++) begin
         @(negedge clk);
         ok = done1;
      end
      #3;
      checks++; if (!ok) begin errors++; $display("FAIL one_timeout got=no_done want=done"); end
      checks++; if (acc1.size() - a !== 1 || acc1[a] !== 32'd5) begin errors++; $display("FAIL one_read got=%0d_reads want=1_at_5", acc1.size() - a); end
      checks++; if (stream_errs(q1, b, 8, 4'd5) !== 0) begin errors++; $display("FAIL one_stream got=%0d_bytes want=8_in_order", q1.size() - b); end
      checks++; if (done1_cnt - d !== 1) begin errors++; $display("FAIL one_done got=%0d want=1", done1_cnt - d); end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL one_busy got=%0h want=0", busy1); end
   endtask
   initial begin
      start0 = 1'b0;
      start1 = 1'b0;
      or0 = 1'b1;
      stall_addr = '1;
      stall_len = 0;
      test_reset;
      test_basic;
      test_waitrequest;
      test_backpressure;
      test_start_busy;
      test_reset_mid;
      test_single_row;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
